// File: rtl/conv1_mp_scheduler_pkg.sv
// Shared widths and stream tokens for the conv1 membrane-potential scheduler.
// Imported by the scheduler and by anything that drives its spike stream.
package conv1_mp_scheduler_pkg;

    localparam int SYNAPSE_INDEX        = 16;
    localparam int CONV1_CHANNEL_O_WIDE = 7;

    localparam logic [SYNAPSE_INDEX-1:0] DEF_START_MARK = 16'hF1FA;
    localparam logic [SYNAPSE_INDEX-1:0] DEF_END_MARK   = 16'hFAF1;

endpackage

// File: rtl/conv1_mp_scheduler.sv
// Walks every conv1 output channel for each popped spike: weight lookup, refresh
// launch, wait for the refresh engine, then next channel, with back-pressure stalls.
module conv1_mp_scheduler
    import conv1_mp_scheduler_pkg::*;
#(
    parameter int                         CH_NUM      = 127,
    parameter logic [SYNAPSE_INDEX-1:0]   START_MARK  = DEF_START_MARK,
    parameter logic [SYNAPSE_INDEX-1:0]   END_MARK    = DEF_END_MARK,
    parameter int                         REF_TIMEOUT = 63
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            in_empty,
    output logic                            in_rd_en,
    input  logic [SYNAPSE_INDEX-1:0]        in_data,
    output logic                            ws_req,
    output logic [SYNAPSE_INDEX-1:0]        ws_index,
    input  logic                            ws_ack,
    output logic [CONV1_CHANNEL_O_WIDE-1:0] channel_o,
    output logic                            mp_valid,
    input  logic                            ref_idle,
    input  logic                            almost_full,
    output logic                            frame_done,
    output logic                            timeout_err,
    output logic [2:0]                      state_dbg
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        POP      = 3'd1,
        DECODE   = 3'd2,
        LOOKUP   = 3'd3,
        LAUNCH   = 3'd4,
        WAIT_REF = 3'd5,
        NEXT_CH  = 3'd6,
        STALL    = 3'd7
    } state_t;

    localparam int CNT_W = $clog2(REF_TIMEOUT + 2);
    localparam logic [CONV1_CHANNEL_O_WIDE-1:0] CH_FIRST = CONV1_CHANNEL_O_WIDE'(1);
    localparam logic [CONV1_CHANNEL_O_WIDE-1:0] CH_LAST  = CONV1_CHANNEL_O_WIDE'(CH_NUM);
    // The refresh engine only leaves IDLE one cycle after mp_valid, so ref_idle
    // is meaningless for the first two WAIT_REF cycles.
    localparam logic [CNT_W-1:0] REF_BLIND = CNT_W'(2);
    localparam logic [CNT_W-1:0] REF_LIMIT = CNT_W'(REF_TIMEOUT);

    state_t                            state, state_nxt;
    logic [CONV1_CHANNEL_O_WIDE-1:0]   channel_nxt;
    logic [SYNAPSE_INDEX-1:0]          idx_reg, idx_nxt;
    logic [CNT_W-1:0]                  ref_cnt, cnt_nxt;
    logic                              terr_nxt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            channel_o   <= CH_FIRST;
            idx_reg     <= '0;
            ref_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            channel_o   <= channel_nxt;
            idx_reg     <= idx_nxt;
            ref_cnt     <= cnt_nxt;
            timeout_err <= terr_nxt;
        end
    end

    // ws_req is a level request raised in LOOKUP and held until the single-cycle
    // ws_ack; the transfer completes on the edge where both are high, and an ack
    // seen in any other state is ignored.
    always_comb begin
        state_nxt   = state;
        channel_nxt = channel_o;
        idx_nxt     = idx_reg;
        cnt_nxt     = ref_cnt;
        terr_nxt    = timeout_err;
        in_rd_en    = 1'b0;
        ws_req      = 1'b0;
        mp_valid    = 1'b0;
        frame_done  = 1'b0;
        case (state)
            IDLE: begin
                if (!in_empty && ref_idle) state_nxt = POP;
            end
            POP: begin
                in_rd_en  = 1'b1;
                state_nxt = DECODE;
            end
            DECODE: begin
                idx_nxt = in_data;
                if (in_data == START_MARK) begin
                    state_nxt = IDLE;
                end else if (in_data == END_MARK) begin
                    frame_done  = 1'b1;
                    channel_nxt = CH_FIRST;
                    state_nxt   = IDLE;
                end else begin
                    channel_nxt = CH_FIRST;
                    state_nxt   = LOOKUP;
                end
            end
            LOOKUP: begin
                ws_req = 1'b1;
                if (ws_ack) state_nxt = LAUNCH;
            end
            LAUNCH: begin
                mp_valid  = 1'b1;
                cnt_nxt   = '0;
                state_nxt = WAIT_REF;
            end
            WAIT_REF: begin
                cnt_nxt = ref_cnt + CNT_W'(1);
                if (ref_cnt >= REF_BLIND && ref_idle) begin
                    state_nxt = NEXT_CH;
                end else if (ref_cnt >= REF_LIMIT) begin
                    terr_nxt  = 1'b1;
                    state_nxt = NEXT_CH;
                end
            end
            NEXT_CH: begin
                if (channel_o == CH_LAST) begin
                    channel_nxt = CH_FIRST;
                    state_nxt   = IDLE;
                end else begin
                    channel_nxt = channel_o + CONV1_CHANNEL_O_WIDE'(1);
                    state_nxt   = almost_full ? STALL : LOOKUP;
                end
            end
            STALL: begin
                if (!almost_full) state_nxt = LOOKUP;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign ws_index  = idx_reg;
    assign state_dbg = state;

endmodule
